// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs big-endian bytes into 32-bit words and writes them
// from BASE_ADDR upward while holding the CPU in reset. Optional checksum word: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [2:0]        dbg_state
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_WRITE = 3'd2,
                             ST_FINISH = 3'd3, ST_CKSUM = 3'd4} state_t;
   logic [31:0] xor_q, xor_d;
`else
   typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_WRITE = 3'd2,
                             ST_FINISH = 3'd3} state_t;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              in_ready_q, in_ready_d;
   logic              imem_we_q, imem_we_d;
   logic              done_q, done_d;
   logic              accept;
   logic [31:0]       shifted;
   logic [31:0]       padded;

   // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1;
   // in_ready is registered, so it already reflects the state the byte will be consumed in.
   assign accept  = in_valid & in_ready_q;
   assign shifted = {word_q[23:0], in_data};
   // A short final word slides its bytes up to the top, leaving zeros in the unfilled low bytes.
   assign padded  = shifted << {(2'd3 - cnt_q), 3'b000};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      ovf_d      = ovf_q;
      err_d      = err_q;
      cpu_hold_d = cpu_hold_q;
      in_ready_d = in_ready_q;
      imem_we_d  = 1'b0;
      done_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d      = xor_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LOAD;
               addr_d     = ADDR_W'(BASE_ADDR);
               word_d     = '0;
               cnt_d      = '0;
               last_d     = 1'b0;
               ovf_d      = 1'b0;
               err_d      = 1'b0;
               cpu_hold_d = 1'b1;
               in_ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               xor_d      = '0;
`endif
            end
         end
         ST_LOAD: begin
            if (accept) begin
               if (ovf_q) begin
                  // Past the top of memory: swallow bytes until the stream ends.
                  if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d    = ST_CKSUM;
                     cnt_d      = '0;
`else
                     state_d    = ST_FINISH;
                     in_ready_d = 1'b0;
                     done_d     = 1'b1;
                     cpu_hold_d = 1'b0;
`endif
                  end
               end else if (in_last || cnt_q == 2'd3) begin
                  word_d     = in_last ? padded : shifted;
                  last_d     = in_last;
                  cnt_d      = '0;
                  state_d    = ST_WRITE;
                  in_ready_d = 1'b0;
                  imem_we_d  = 1'b1;
               end else begin
                  word_d = shifted;
                  cnt_d  = cnt_q + 2'd1;
               end
            end
         end
         ST_WRITE: begin
            addr_d = addr_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d  = xor_q ^ word_q;
`endif
            if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d    = ST_CKSUM;
               in_ready_d = 1'b1;
`else
               state_d    = ST_FINISH;
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
`endif
            end else begin
               state_d    = ST_LOAD;
               in_ready_d = 1'b1;
               if (addr_q == {ADDR_W{1'b1}}) begin
                  err_d = 1'b1;
                  ovf_d = 1'b1;
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CKSUM: begin
            if (accept) begin
               word_d = shifted;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d    = ST_FINISH;
                  in_ready_d = 1'b0;
                  done_d     = 1'b1;
                  if (shifted == xor_q) cpu_hold_d = 1'b0;
                  else                  err_d      = 1'b1;
               end
            end
         end
`endif
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         word_q     <= '0;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         cpu_hold_q <= 1'b1;
         in_ready_q <= 1'b0;
         imem_we_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
         cpu_hold_q <= cpu_hold_d;
         in_ready_q <= in_ready_d;
         imem_we_q  <= imem_we_d;
         done_q     <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = word_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign err        = err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: captures every memory write and done pulse, then checks
// them against hand-derived expected writes per scenario.
module tb_imem_loader;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_last = 1'b0;
   logic          in_ready, imem_we, cpu_hold, done, err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [2:0]    dbg_state;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int wr_cyc = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   logic wr_hold = 1'b0;
   logic done_hold = 1'b0;
   logic done_err = 1'b0;
   logic [31:0] last_cksum = '0;
   logic [AW+31:0] exp_q[$];
   logic [AW+31:0] wr_log[$];

   imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: sample outputs on the falling edge
   always @(negedge clk) begin
      if (imem_we) begin
         wr_log.push_back({imem_addr, imem_wdata});
         wr_cyc  = cyc;
         wr_hold = cpu_hold;
      end
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_hold = cpu_hold;
         done_err  = err;
      end
   end

   // driver tasks
   task automatic clear_log();
      wr_log.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL byte_timeout: in_ready=%b required=1 for byte %h", in_ready, d);
      end
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic last, input int gap);
      send_byte(w[31:24], 1'b0, gap);
      send_byte(w[23:16], 1'b0, gap);
      send_byte(w[15:8],  1'b0, gap);
      send_byte(w[7:0],   last, gap);
   endtask

   task automatic maybe_cksum(input logic [31:0] x);
      last_cksum = x;
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(x, 1'b0, 0);
`endif
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_cnt == 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done_cnt == 0) begin
         bad++;
         $display("FAIL done_timeout: done_cnt=%0d required>=1", done_cnt);
      end
      @(posedge clk); #1;
   endtask

   // tests
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state: got=%0d exp=0", dbg_state); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_ready: got=%b exp=0", in_ready); end
      total++; if (imem_we !== 1'b0)   begin bad++; $display("FAIL rst_we: got=%b exp=0", imem_we); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got=%b exp=0", done); end
      total++; if (err !== 1'b0)       begin bad++; $display("FAIL rst_err: got=%b exp=0", err); end
      total++; if (cpu_hold !== 1'b1)  begin bad++; $display("FAIL rst_hold: got=%b exp=1", cpu_hold); end
      total++; if (imem_addr !== '0)   begin bad++; $display("FAIL rst_addr: got=%h exp=0", imem_addr); end
      total++; if (imem_wdata !== '0)  begin bad++; $display("FAIL rst_wdata: got=%h exp=0", imem_wdata); end
      reset = 1'b1;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL idle_ready: got=%b exp=0", in_ready); end
   endtask

   task automatic test_basic(input int gap, input string tag);
      int acc;
      clear_log();
      exp_q.push_back({8'd0, 32'h24080005});
      exp_q.push_back({8'd1, 32'h0000000C});
      do_start();
      total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL %s_hold_start: got=%b exp=1", tag, cpu_hold); end
      send_word(32'h24080005, 1'b0, gap);
      send_word(32'h0000000C, 1'b1, gap);
      acc = acc_cyc;
      maybe_cksum(32'h24080005 ^ 32'h0000000C);
      wait_done();
      total++;
      if (wr_log.size() != exp_q.size()) begin
         bad++; $display("FAIL %s_nwrites: got=%0d exp=%0d", tag, wr_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
         total++;
         if (wr_log[i] !== exp_q[i]) begin
            bad++; $display("FAIL %s_write%0d: got=%h exp=%h", tag, i, wr_log[i], exp_q[i]);
         end
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      total++; if (wr_cyc != acc) begin bad++; $display("FAIL %s_latency: got=%0d exp=%0d", tag, wr_cyc - acc + 1, 1); end
      total++; if (done_cyc != wr_cyc + 1) begin bad++; $display("FAIL %s_done_time: got=%0d exp=%0d", tag, done_cyc, wr_cyc + 1); end
`endif
      total++; if (wr_hold !== 1'b1)   begin bad++; $display("FAIL %s_hold_at_write: got=%b exp=1", tag, wr_hold); end
      total++; if (done_hold !== 1'b0) begin bad++; $display("FAIL %s_hold_at_done: got=%b exp=0", tag, done_hold); end
      total++; if (done_err !== 1'b0)  begin bad++; $display("FAIL %s_err: got=%b exp=0", tag, done_err); end
      total++; if (done_cnt != 1)      begin bad++; $display("FAIL %s_done_count: got=%0d exp=1", tag, done_cnt); end
   endtask

   task automatic test_partial();
      clear_log();
      exp_q.push_back({8'd0, 32'hAABBCC00});
      do_start();
      send_byte(8'hAA, 1'b0, 0);
      send_byte(8'hBB, 1'b0, 0);
      send_byte(8'hCC, 1'b1, 0);
      maybe_cksum(32'hAABBCC00);
      wait_done();
      total++; if (wr_log.size() != 1) begin bad++; $display("FAIL partial_nwrites: got=%0d exp=1", wr_log.size()); end
      total++;
      if (wr_log.size() == 0 || wr_log[0] !== exp_q[0]) begin
         bad++; $display("FAIL partial_word: got=%h exp=%h", (wr_log.size() != 0) ? wr_log[0] : '0, exp_q[0]);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] w;
      logic [31:0] x;
      logic [7:0]  b;
      int nbad;
      clear_log();
      x = '0;
      do_start();
      for (int i = 0; i < 257; i++) begin
         b = i[7:0];
         w = {b, 8'h3C, ~b, b ^ 8'h81};
         if (i < 256) begin
            exp_q.push_back({b, w});
            x = x ^ w;
         end
         send_word(w, (i == 256), 0);
      end
      maybe_cksum(x);
      wait_done();
      total++; if (wr_log.size() != 256) begin bad++; $display("FAIL ovf_nwrites: got=%0d exp=256", wr_log.size()); end
      nbad = 0;
      for (int i = 0; i < 256 && i < wr_log.size(); i++) if (wr_log[i] !== exp_q[i]) nbad++;
      total++; if (nbad != 0) begin bad++; $display("FAIL ovf_contents: got=%0d wrong words exp=0", nbad); end
      total++; if (done_err !== 1'b1) begin bad++; $display("FAIL ovf_err: got=%b exp=1", done_err); end
      total++; if (done_cnt != 1)     begin bad++; $display("FAIL ovf_done: got=%0d exp=1", done_cnt); end
      total++; if (err !== 1'b1)      begin bad++; $display("FAIL ovf_err_sticky: got=%b exp=1", err); end
      do_start();
      total++; if (err !== 1'b0)      begin bad++; $display("FAIL start_clears_err: got=%b exp=0", err); end
      send_word(32'h11223344, 1'b1, 0);
      maybe_cksum(32'h11223344);
      wait_done();
   endtask

   task automatic test_reset_mid();
      clear_log();
      exp_q.push_back({8'd0, 32'h24080005});
      exp_q.push_back({8'd1, 32'h0000000C});
      do_start();
      send_byte(8'h11, 1'b0, 0);
      send_byte(8'h22, 1'b0, 0);
      reset = 1'b0;
      #1;
      total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL mid_rst_state: got=%0d exp=0", dbg_state); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL mid_rst_ready: got=%b exp=0", in_ready); end
      total++; if (cpu_hold !== 1'b1)  begin bad++; $display("FAIL mid_rst_hold: got=%b exp=1", cpu_hold); end
      @(posedge clk); #1;
      reset = 1'b1;
      do_start();
      send_word(32'h24080005, 1'b0, 0);
      send_word(32'h0000000C, 1'b1, 0);
      maybe_cksum(32'h24080005 ^ 32'h0000000C);
      wait_done();
      total++; if (wr_log.size() != 2) begin bad++; $display("FAIL mid_nwrites: got=%0d exp=2", wr_log.size()); end
      for (int i = 0; i < 2 && i < wr_log.size(); i++) begin
         total++;
         if (wr_log[i] !== exp_q[i]) begin
            bad++; $display("FAIL mid_write%0d: got=%h exp=%h", i, wr_log[i], exp_q[i]);
         end
      end
      total++; if (wr_hold !== 1'b1)   begin bad++; $display("FAIL mid_hold_at_write: got=%b exp=1", wr_hold); end
      total++; if (done_hold !== 1'b0) begin bad++; $display("FAIL mid_hold_at_done: got=%b exp=0", done_hold); end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      clear_log();
      do_start();
      send_word(32'h00000001, 1'b0, 0);
      send_word(32'h00000003, 1'b1, 0);
      send_word(32'h00000002, 1'b0, 0);
      wait_done();
      total++; if (done_err !== 1'b0)  begin bad++; $display("FAIL cks_ok_err: got=%b exp=0", done_err); end
      total++; if (done_hold !== 1'b0) begin bad++; $display("FAIL cks_ok_hold: got=%b exp=0", done_hold); end
      clear_log();
      do_start();
      send_word(32'h00000001, 1'b0, 0);
      send_word(32'h00000003, 1'b1, 0);
      send_word(32'h00000005, 1'b0, 0);
      wait_done();
      total++; if (done_err !== 1'b1)  begin bad++; $display("FAIL cks_bad_err: got=%b exp=1", done_err); end
      total++; if (cpu_hold !== 1'b1)  begin bad++; $display("FAIL cks_bad_hold: got=%b exp=1", cpu_hold); end
      total++; if (wr_log.size() != 2) begin bad++; $display("FAIL cks_nwrites: got=%0d exp=2", wr_log.size()); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic(0, "basic");
      test_partial();
      test_basic(1, "stall");
      test_overflow();
      test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: time=%0t limit=200000", $time);
      $fatal(1, "timeout");
   end
endmodule
